// File: rtl/imm_extend_pipe_pkg.sv
// Shared definitions for the immediate-extension stage.
//   imm_mode_e : 2-bit extension mode codes used by decode and the ext core.
package imm_extend_pipe_pkg;

  typedef enum logic [1:0] {
    IMM_SEXT     = 2'b00,
    IMM_ZEXT     = 2'b01,
    IMM_SEXT_SHL = 2'b10,
    IMM_UPPER    = 2'b11
  } imm_mode_e;

endpackage

// File: rtl/imm_extend_pipe_ext_core.sv
// Combinational immediate extender, reusable outside the pipe stage.
//   imm_in [IN_W]  raw immediate field
//   mode   [2]     extension mode (imm_mode_e codes)
//   value  [OUT_W] extended immediate
//   ovf            significant bits shifted out in IMM_SEXT_SHL, else 0
module imm_ext_core
  import imm_extend_pipe_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16,
  parameter int SHIFT = 1
) (
  input  logic [IN_W-1:0]  imm_in,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] value,
  output logic             ovf
);

  logic signed [IN_W-1:0]  imm_s;
  logic signed [OUT_W-1:0] sext;
  logic signed [OUT_W-1:0] shl;
  logic        [OUT_W-1:0] zext;
  logic        [OUT_W-1:0] upper;
  logic                    shl_ovf;

  assign imm_s = imm_in;
  assign sext  = OUT_W'(imm_s);
  assign zext  = OUT_W'(imm_in);
  assign upper = zext << (OUT_W - IN_W);
  assign shl   = sext << SHIFT;
  // Bits were lost iff shifting back arithmetically does not recover the
  // sign-extended value, i.e. the top SHIFT+1 bits of sext differ.
  assign shl_ovf = ((shl >>> SHIFT) != sext);

  always_comb begin
    value = '0;
    ovf   = 1'b0;
    case (mode)
      IMM_SEXT:     value = sext;
      IMM_ZEXT:     value = zext;
      IMM_SEXT_SHL: begin
        value = shl;
        ovf   = shl_ovf;
      end
      IMM_UPPER:    value = upper;
      default:      value = '0;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage with a 2-entry valid/ready buffer.
// Extension happens at push time; the buffer stores {value, tag, ovf}.
//   clk, rst_n            clock, async active-low reset
//   flush                 synchronous clear of all buffered entries
//   in_valid/in_ready     input handshake (in_ready from registered count)
//   imm_in, mode, tag_in  input payload
//   out_valid/out_ready   output handshake
//   imm_out, tag_out, ovf head entry payload, zero when empty
module imm_extend_pipe
  import imm_extend_pipe_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16,
  parameter int SHIFT = 1,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm_in,
  input  logic [1:0]       mode,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] imm_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             ovf
);

  logic [OUT_W-1:0] ext_value;
  logic             ext_ovf;

  logic [OUT_W-1:0] val_q [2];
  logic [TAG_W-1:0] tag_q [2];
  logic [1:0]       ovf_q;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_core (
    .imm_in (imm_in),
    .mode   (mode),
    .value  (ext_value),
    .ovf    (ext_ovf)
  );

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q[0] <= '0;
      val_q[1] <= '0;
      tag_q[0] <= '0;
      tag_q[1] <= '0;
      ovf_q    <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else if (flush) begin
      val_q[0] <= '0;
      val_q[1] <= '0;
      tag_q[0] <= '0;
      tag_q[1] <= '0;
      ovf_q    <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) begin
        val_q[wr_ptr] <= ext_value;
        tag_q[wr_ptr] <= tag_in;
        ovf_q[wr_ptr] <= ext_ovf;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Stale slot contents are masked so an empty stage presents all zeros.
  assign imm_out = out_valid ? val_q[rd_ptr] : '0;
  assign tag_out = out_valid ? tag_q[rd_ptr] : '0;
  assign ovf     = out_valid ? ovf_q[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;
  import imm_extend_pipe_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  imm_in;
  logic [1:0]  mode;
  logic [3:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] imm_out;
  logic [3:0]  tag_out;
  logic        ovf;

  logic        in8_valid;
  logic        in8_ready;
  logic [7:0]  imm8_in;
  logic [1:0]  mode8;
  logic        out8_valid;
  logic [7:0]  imm8_out;
  logic [3:0]  tag8_out;
  logic        ovf8;

  int total;
  int bad;

  imm_extend_pipe u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm_in    (imm_in),
    .mode      (mode),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm_out   (imm_out),
    .tag_out   (tag_out),
    .ovf       (ovf)
  );

  imm_extend_pipe #(.IN_W(8), .OUT_W(8), .SHIFT(1), .TAG_W(4)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .in_valid  (in8_valid),
    .in_ready  (in8_ready),
    .imm_in    (imm8_in),
    .mode      (mode8),
    .tag_in    (4'h5),
    .out_valid (out8_valid),
    .out_ready (1'b1),
    .imm_out   (imm8_out),
    .tag_out   (tag8_out),
    .ovf       (ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one entry into the empty 16-bit stage with out_ready=1 and check
  // the head one cycle later, then let it pop.
  task automatic push_check(input string tag, input logic [1:0] m, input logic [3:0] imm,
                            input logic [3:0] t, input logic [15:0] exp_val, input logic exp_ovf);
    in_valid = 1'b1;
    mode     = m;
    imm_in   = imm;
    tag_in   = t;
    step();
    in_valid = 1'b0;
    check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_val({tag, "_val"}, 32'(imm_out), 32'(exp_val));
    check_val({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    check_val({tag, "_tag"}, 32'(tag_out), 32'(t));
    step();
    check_val({tag, "_empty"}, 32'(out_valid), 32'd0);
  endtask

  task automatic push8(input string tag, input logic [1:0] m, input logic [7:0] imm,
                       input logic [7:0] exp_val, input logic exp_ovf);
    in8_valid = 1'b1;
    mode8     = m;
    imm8_in   = imm;
    step();
    in8_valid = 1'b0;
    check_val({tag, "_valid"}, 32'(out8_valid), 32'd1);
    check_val({tag, "_val"}, 32'(imm8_out), 32'(exp_val));
    check_val({tag, "_ovf"}, 32'(ovf8), 32'(exp_ovf));
    step();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    imm_in    = '0;
    mode      = IMM_SEXT;
    tag_in    = '0;
    out_ready = 1'b1;
    in8_valid = 1'b0;
    imm8_in   = '0;
    mode8     = IMM_SEXT;

    #12;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_imm_out", 32'(imm_out), 32'd0);
    check_val("rst_tag_out", 32'(tag_out), 32'd0);
    check_val("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    step();
    check_val("rst_in_ready", 32'(in_ready), 32'd1);

    push_check("sext",     IMM_SEXT,     4'b1010, 4'h3, 16'hFFFA, 1'b0);
    push_check("sext_pos", IMM_SEXT,     4'h5,    4'h4, 16'h0005, 1'b0);
    push_check("zext",     IMM_ZEXT,     4'hA,    4'h6, 16'h000A, 1'b0);
    push_check("upper",    IMM_UPPER,    4'hA,    4'h9, 16'hA000, 1'b0);
    push_check("shl_pos",  IMM_SEXT_SHL, 4'h7,    4'hC, 16'h000E, 1'b0);
    push_check("shl_neg",  IMM_SEXT_SHL, 4'h8,    4'hF, 16'hFFF0, 1'b0);

    push8("w8_shl_ovf",  IMM_SEXT_SHL, 8'h40, 8'h80, 1'b1);
    push8("w8_shl_ok",   IMM_SEXT_SHL, 8'hC0, 8'h80, 1'b0);
    push8("w8_sext",     IMM_SEXT,     8'h80, 8'h80, 1'b0);
    push8("w8_upper",    IMM_UPPER,    8'h3C, 8'h3C, 1'b0);

    // Backpressure: three back-to-back pushes, only two fit.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      mode     = IMM_ZEXT;
      imm_in   = 4'(k + 1);
      tag_in   = 4'(k + 1);
      check_val($sformatf("bp_in_ready%0d", k), 32'(in_ready), (k < 2) ? 32'd1 : 32'd0);
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("bp_hold_val%0d", k), 32'(imm_out), 32'h1);
      check_val($sformatf("bp_hold_tag%0d", k), 32'(tag_out), 32'h1);
      check_val($sformatf("bp_hold_vld%0d", k), 32'(out_valid), 32'd1);
      step();
    end
    out_ready = 1'b1;
    step();
    check_val("bp_second_val", 32'(imm_out), 32'h2);
    check_val("bp_second_tag", 32'(tag_out), 32'h2);
    check_val("bp_freed_ready", 32'(in_ready), 32'd1);
    step();
    check_val("bp_drained", 32'(out_valid), 32'd0);

    // Streaming: simultaneous push and pop every cycle.
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      mode     = IMM_ZEXT;
      imm_in   = 4'(i);
      tag_in   = 4'(i);
      step();
      check_val($sformatf("stream_tag%0d", i), 32'(tag_out), 32'(i));
      check_val($sformatf("stream_vld%0d", i), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    step();
    check_val("stream_end", 32'(out_valid), 32'd0);

    // Flush with a full buffer and a same-cycle push.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    mode      = IMM_SEXT;
    imm_in    = 4'hF;
    tag_in    = 4'h7;
    step();
    step();
    check_val("fl_full", 32'(in_ready), 32'd0);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_val("fl_out_valid", 32'(out_valid), 32'd0);
    check_val("fl_in_ready", 32'(in_ready), 32'd1);
    check_val("fl_imm_out", 32'(imm_out), 32'd0);
    check_val("fl_tag_out", 32'(tag_out), 32'd0);
    step();
    check_val("fl_dropped", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stream.
    in_valid = 1'b1;
    imm_in   = 4'h9;
    tag_in   = 4'hB;
    step();
    step();
    in_valid = 1'b0;
    check_val("mr_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mr_out_valid", 32'(out_valid), 32'd0);
    check_val("mr_imm_out", 32'(imm_out), 32'd0);
    check_val("mr_tag_out", 32'(tag_out), 32'd0);
    check_val("mr_ovf", 32'(ovf), 32'd0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    check_val("mr_in_ready", 32'(in_ready), 32'd1);
    check_val("mr_empty", 32'(out_valid), 32'd0);

    push_check("post_rst", IMM_SEXT, 4'b1010, 4'h2, 16'hFFFA, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
